// File: rtl/fdiv_arbiter_if.sv
// rtl/fdiv_arbiter_if.sv - requester, divider and response signals of the shared fdiv arbiter
interface fdiv_arbiter_if #(
    parameter int TAG_W = 5
);
    logic             req0_valid;
    logic             req0_ready;
    logic [31:0]      req0_x1;
    logic [31:0]      req0_x2;
    logic [TAG_W-1:0] req0_tag;
    logic             req1_valid;
    logic             req1_ready;
    logic [31:0]      req1_x1;
    logic [31:0]      req1_x2;
    logic [TAG_W-1:0] req1_tag;
    logic [31:0]      div_x1;
    logic [31:0]      div_x2;
    logic [31:0]      div_y;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_y;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_id;
    logic             busy;

    modport slave (
        input  req0_valid, req0_x1, req0_x2, req0_tag,
        output req0_ready,
        input  req1_valid, req1_x1, req1_x2, req1_tag,
        output req1_ready,
        output div_x1, div_x2,
        input  div_y,
        output rsp_valid, rsp_y, rsp_tag, rsp_id,
        input  rsp_ready,
        output busy
    );

    modport master (
        output req0_valid, req0_x1, req0_x2, req0_tag,
        input  req0_ready,
        output req1_valid, req1_x1, req1_x2, req1_tag,
        input  req1_ready,
        input  div_x1, div_x2,
        output div_y,
        input  rsp_valid, rsp_y, rsp_tag, rsp_id,
        output rsp_ready,
        input  busy
    );
endinterface

// File: rtl/fdiv_arbiter.sv
// rtl/fdiv_arbiter.sv - round-robin sharing of one pipelined fdiv with credit-limited response FIFO
module fdiv_arbiter #(
    parameter int LATENCY    = 9,
    parameter int TAG_W      = 5,
    parameter int FIFO_DEPTH = 16
) (
    input  logic           clk,
    input  logic           rst,
    fdiv_arbiter_if.slave  bus
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int ENT_W = 32 + 1 + TAG_W;

    logic [CNT_W-1:0] cnt;
    logic             prio;
    logic             credit_ok;
    logic             any_valid;
    logic             gnt_id;
    logic             issue;
    logic             push;
    logic             pop;
    logic             empty;
    logic             full;
    logic [TAG_W-1:0] gnt_tag;
    logic [ENT_W-1:0] head;

    logic             pipe_v   [LATENCY];
    logic             pipe_id  [LATENCY];
    logic [TAG_W-1:0] pipe_tag [LATENCY];

    logic [ENT_W-1:0] mem [FIFO_DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // Credit covers both the divider pipe and the FIFO, so the FIFO can never overflow.
    assign credit_ok = cnt < CNT_W'(FIFO_DEPTH);
    assign any_valid = bus.req0_valid | bus.req1_valid;
    assign gnt_id    = (bus.req0_valid && bus.req1_valid) ? prio : bus.req1_valid;
    assign issue     = !rst && credit_ok && any_valid;

    assign bus.req0_ready = issue && !gnt_id;
    assign bus.req1_ready = issue && gnt_id;
    assign bus.div_x1     = issue ? (gnt_id ? bus.req1_x1 : bus.req0_x1) : 32'h0;
    assign bus.div_x2     = issue ? (gnt_id ? bus.req1_x2 : bus.req0_x2) : 32'h0;
    assign gnt_tag        = gnt_id ? bus.req1_tag : bus.req0_tag;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push  = pipe_v[LATENCY-1];
    assign pop   = !empty && bus.rsp_ready;

    assign head          = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign bus.rsp_valid = !empty;
    assign bus.rsp_y     = head[ENT_W-1 -: 32];
    assign bus.rsp_id    = head[TAG_W];
    assign bus.rsp_tag   = head[TAG_W-1:0];
    assign bus.busy      = (cnt != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            prio   <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < LATENCY; i++) pipe_v[i] <= 1'b0;
        end else begin
            assert (!(push && full));
            if (issue && !pop)
                cnt <= cnt + 1'b1;
            else if (!issue && pop)
                cnt <= cnt - 1'b1;
            if (issue)
                prio <= ~gnt_id;
            pipe_v[0] <= issue;
            for (int i = 1; i < LATENCY; i++) pipe_v[i] <= pipe_v[i-1];
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Payload needs no reset: it is only consumed where the matching valid bit is set.
    always_ff @(posedge clk) begin
        pipe_id[0]  <= gnt_id;
        pipe_tag[0] <= gnt_tag;
        for (int i = 1; i < LATENCY; i++) begin
            pipe_id[i]  <= pipe_id[i-1];
            pipe_tag[i] <= pipe_tag[i-1];
        end
        if (push)
            mem[wr_ptr[AW-1:0]] <= {bus.div_y, pipe_id[LATENCY-1], pipe_tag[LATENCY-1]};
    end
endmodule

// File: tb/tb_fdiv_arbiter.sv
// tb/tb_fdiv_arbiter.sv - self-checking bench for fdiv_arbiter with a stand-in pipelined divider
module tb_fdiv_arbiter;
    localparam int LAT = 9;
    localparam int DEPTH = 16;

    typedef struct {
        logic [31:0] y;
        logic        id;
        logic [4:0]  tag;
        int          due;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    bit   chk_en = 1'b0;

    fdiv_arbiter_if #(.TAG_W(5)) bus ();

    fdiv_arbiter #(.LATENCY(LAT), .TAG_W(5), .FIFO_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Divider stand-in: exact quotient for power-of-two divisors, fixed LAT-cycle latency.
    function automatic logic [31:0] fdiv_ref(input logic [31:0] a, input logic [31:0] b);
        return a - b + 32'h3F800000;
    endfunction

    logic [31:0] dpipe [LAT];
    always @(posedge clk) begin
        dpipe[0] <= fdiv_ref(bus.div_x1, bus.div_x2);
        for (int i = 1; i < LAT; i++) dpipe[i] <= dpipe[i-1];
    end
    assign bus.div_y = dpipe[LAT-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: credit count, round-robin pointer, in-flight list and response queue.
    ent_t pend[$];
    ent_t mfifo[$];
    int   cnt_m = 0;
    logic prio_m = 1'b0;
    int   mcyc = 0;

    always @(negedge clk) begin
        logic exp_rv, g, iss, popm;
        ent_t e;
        if (chk_en) begin
            exp_rv = (mfifo.size() != 0);
            chk("rsp_valid", bus.rsp_valid, exp_rv);
            if (exp_rv) begin
                chk("rsp_y", bus.rsp_y, mfifo[0].y);
                chk("rsp_id", bus.rsp_id, mfifo[0].id);
                chk("rsp_tag", bus.rsp_tag, mfifo[0].tag);
            end
            g   = (bus.req0_valid && bus.req1_valid) ? prio_m : bus.req1_valid;
            iss = !rst && (cnt_m < DEPTH) && (bus.req0_valid || bus.req1_valid);
            chk("req0_ready", bus.req0_ready, iss && !g);
            chk("req1_ready", bus.req1_ready, iss && g);
            chk("div_x1", bus.div_x1, iss ? (g ? bus.req1_x1 : bus.req0_x1) : 32'h0);
            chk("div_x2", bus.div_x2, iss ? (g ? bus.req1_x2 : bus.req0_x2) : 32'h0);
            chk("busy", bus.busy, cnt_m != 0);
            if (rst) begin
                pend.delete();
                mfifo.delete();
                cnt_m  = 0;
                prio_m = 1'b0;
            end else begin
                popm = exp_rv && bus.rsp_ready;
                if (popm) void'(mfifo.pop_front());
                while (pend.size() != 0 && pend[0].due == mcyc) mfifo.push_back(pend.pop_front());
                if (iss) begin
                    e.y   = g ? fdiv_ref(bus.req1_x1, bus.req1_x2) : fdiv_ref(bus.req0_x1, bus.req0_x2);
                    e.id  = g;
                    e.tag = g ? bus.req1_tag : bus.req0_tag;
                    e.due = mcyc + LAT;
                    pend.push_back(e);
                    prio_m = ~g;
                end
                cnt_m = cnt_m + (iss ? 1 : 0) - (popm ? 1 : 0);
            end
        end
        mcyc++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy !== 1'b0 && n < 200) begin
            step(1);
            n++;
        end
        chk("drain_idle", bus.busy, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [31:0] pw [4];
        int lat, n, w;
        pw[0] = 32'h3F800000; pw[1] = 32'h40000000; pw[2] = 32'h40800000; pw[3] = 32'h3F000000;
        rst = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_x1 = 32'h0; bus.req0_x2 = 32'h0; bus.req0_tag = '0;
        bus.req1_valid = 1'b1; bus.req1_x1 = 32'h0; bus.req1_x2 = 32'h0; bus.req1_tag = '0;
        bus.rsp_ready = 1'b0;
        step(1);
        chk_en = 1'b1;
        chk("rst_req0_ready", bus.req0_ready, 1'b0);
        chk("rst_req1_ready", bus.req1_ready, 1'b0);
        chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_rsp_y", bus.rsp_y, 32'h0);
        chk("rst_rsp_tag", bus.rsp_tag, 32'h0);
        chk("rst_rsp_id", bus.rsp_id, 1'b0);
        chk("rst_div_x1", bus.div_x1, 32'h0);
        chk("rst_busy", bus.busy, 1'b0);
        step(1);
        rst = 1'b0; bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; bus.rsp_ready = 1'b1;
        step(1);

        // single op 6.0/2.0, first response exactly LAT+1 cycles after issue
        bus.req0_valid = 1'b1; bus.req0_x1 = 32'h40C00000; bus.req0_x2 = 32'h40000000; bus.req0_tag = 5'd3;
        step(1);
        bus.req0_valid = 1'b0;
        lat = 1;
        while (!bus.rsp_valid && lat < 30) begin
            step(1);
            lat++;
        end
        chk("t1_latency", lat, 10);
        chk("t1_rsp_y", bus.rsp_y, 32'h40400000);
        chk("t1_rsp_tag", bus.rsp_tag, 5'd3);
        chk("t1_rsp_id", bus.rsp_id, 1'b0);
        wait_idle();

        // both requesters continuously valid: alternate grants
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            bus.req0_x1 = $urandom; bus.req0_x2 = pw[$urandom_range(0, 3)]; bus.req0_tag = 5'(i);
            bus.req1_x1 = $urandom; bus.req1_x2 = pw[$urandom_range(0, 3)]; bus.req1_tag = 5'(i + 16);
            step(1);
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        wait_idle();

        // consumer stalled: credit limits issues to DEPTH
        bus.rsp_ready = 1'b0; bus.req0_valid = 1'b1;
        n = 0;
        for (int i = 0; i < 25; i++) begin
            bus.req0_x1 = $urandom; bus.req0_x2 = pw[i % 4]; bus.req0_tag = 5'(i);
            #1;
            if (bus.req0_ready) n++;
            step(1);
        end
        chk("t3_issue_count", n, 16);
        chk("t3_ready_low", bus.req0_ready, 1'b0);
        bus.rsp_ready = 1'b1;
        #1;
        chk("t3_ready_pop_cycle", bus.req0_ready, 1'b0);
        step(1);
        chk("t3_ready_after_pop", bus.req0_ready, 1'b1);

        // full credit with req1: pop and issue overlap under back-pressure
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b1; bus.rsp_ready = 1'b0;
        bus.req1_x1 = 32'h41200000; bus.req1_x2 = 32'h40000000; bus.req1_tag = 5'd20;
        step(1);
        bus.rsp_ready = 1'b1;
        #1;
        chk("t4_credit_full", bus.req1_ready, 1'b0);
        step(1);
        for (int i = 0; i < 10; i++) begin
            bus.req1_x1 = $urandom; bus.req1_x2 = pw[i % 4]; bus.req1_tag = 5'(21 + i);
            #1;
            chk("t4_req1_ready", bus.req1_ready, 1'b1);
            step(1);
        end
        bus.req1_valid = 1'b0;
        wait_idle();

        // reset mid-flight drops everything and clears prio
        bus.req0_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.req0_x1 = 32'h41000000; bus.req0_x2 = pw[i]; bus.req0_tag = 5'(i + 7);
            step(1);
        end
        bus.req0_valid = 1'b0;
        step(1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        #1;
        chk("t5_busy_after_rst", bus.busy, 1'b0);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.rsp_valid) n++;
            step(1);
        end
        chk("t5_no_rsp", n, 0);
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        #1;
        chk("t5_prio0_req0", bus.req0_ready, 1'b1);
        chk("t5_prio0_req1", bus.req1_ready, 1'b0);
        step(1);
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        wait_idle();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(1);

        // req1 alone with prio=0: granted every cycle, tags return in order
        bus.req1_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            bus.req1_x1 = 32'h42000000 + 32'(i); bus.req1_x2 = pw[i % 4]; bus.req1_tag = 5'(i);
            #1;
            chk("t6_req1_ready", bus.req1_ready, 1'b1);
            step(1);
        end
        bus.req1_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            w = 0;
            while (!bus.rsp_valid && w < 20) begin
                step(1);
                w++;
            end
            chk("t6_rsp_tag", bus.rsp_tag, 5'(i));
            chk("t6_rsp_id", bus.rsp_id, 1'b1);
            step(1);
        end
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
